// File: rtl/scr1_imem_tcm_responder_pkg.sv
// Shared IMEM interface widths and command/response encodings used by the TCM responder.
package scr1_imem_tcm_responder_pkg;

    localparam int unsigned SCR1_IMEM_AWIDTH = 32;
    localparam int unsigned SCR1_IMEM_DWIDTH = 32;

    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;

endpackage

// File: rtl/scr1_imem_tcm_responder.sv
// IMEM target: accepts fetches, reads a synchronous SRAM and returns RDY_OK/RDY_ER.
// Optional SCR1_IMEM_RESP_PARITY_EN adds ram_rpar and flags parity errors as RDY_ER.
module scr1_imem_tcm_responder
    import scr1_imem_tcm_responder_pkg::*;
#(
    parameter int unsigned MEM_AWIDTH  = 14,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic                         imem_req_ack,
    input  logic                         imem_req,
    input  type_scr1_mem_cmd_e           imem_cmd,
    input  logic [SCR1_IMEM_AWIDTH-1:0]  imem_addr,
    output logic [SCR1_IMEM_DWIDTH-1:0]  imem_rdata,
    output type_scr1_mem_resp_e          imem_resp,
    output logic                         ram_cs,
    output logic [MEM_AWIDTH-1:0]        ram_addr,
    input  logic [31:0]                  ram_rdata
`ifdef SCR1_IMEM_RESP_PARITY_EN
    ,
    input  logic                         ram_rpar
`endif
);

    localparam int unsigned CNT_W = 3;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;

    logic               par_err;
    logic               resp_ok;
    logic               req_bad;
    logic               accept;

`ifdef SCR1_IMEM_RESP_PARITY_EN
    assign par_err = (state_q == ST_RESP) & ~err_q & (^{ram_rdata, ram_rpar});
`else
    assign par_err = 1'b0;
`endif

    // A response cycle may overlap the next accept only when it is a clean OK
    assign resp_ok = (state_q == ST_RESP) & ~err_q & ~par_err;
    assign accept  = ~rst & imem_req & ((state_q == ST_IDLE) | resp_ok);
    assign req_bad = (imem_cmd != SCR1_MEM_CMD_RD) | (imem_addr[1:0] != 2'b00);

    // Upper address bits are decoded by the router, not here
    generate
        if (MEM_AWIDTH + 2 < SCR1_IMEM_AWIDTH) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^imem_addr[SCR1_IMEM_AWIDTH-1:MEM_AWIDTH+2];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (accept) begin
                    if (req_bad) begin
                        state_d = ST_RESP;
                        err_d   = 1'b1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_LOAD;
                        err_d   = 1'b0;
                    end else begin
                        state_d = ST_RESP;
                        err_d   = 1'b0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        imem_req_ack = accept;
        ram_cs       = accept & ~req_bad;
        ram_addr     = '0;
        imem_resp    = SCR1_MEM_RESP_NOTRDY;
        imem_rdata   = '0;
        if (accept & ~req_bad) begin
            ram_addr = imem_addr[MEM_AWIDTH+1:2];
        end
        if (~rst & (state_q == ST_RESP)) begin
            if (resp_ok) begin
                imem_resp  = SCR1_MEM_RESP_RDY_OK;
                imem_rdata = SCR1_IMEM_DWIDTH'(ram_rdata);
            end else begin
                imem_resp  = SCR1_MEM_RESP_RDY_ER;
            end
        end
    end

`ifdef SCR1_SIM_ENV
    a_cs_only_on_accept : assert property (@(posedge clk) ram_cs |-> imem_req_ack);
    a_req_known : assert property (@(posedge clk) disable iff (rst)
        imem_req |-> !$isunknown({imem_cmd, imem_addr}));
`endif

endmodule
